// File: rtl/serial_frame_pkg.sv
// Shared types and defaults for the serial frame router: FSM state encoding,
// default geometry, and the address-width helper.
package serial_frame_pkg;

  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_LEN_W     = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4
  } state_t;

  // A single-port router still carries a one-bit address field on the line.
  function automatic int port_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/param_down_counter.sv
// Loadable down-counter holding the remaining payload bit count.
// Load has priority over enable; the count saturates at zero.
module param_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= din;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/serial_frame_router.sv
// Parses start/address/length framing on a single serial line and forwards
// the payload bits to one of NUM_PORTS registered serial outputs.
module serial_frame_router
  import serial_frame_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int PORT_W    = port_width(NUM_PORTS),
  parameter int LEN_W     = DEF_LEN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ser_in,
  output logic [NUM_PORTS-1:0] ser_out,
  output logic [NUM_PORTS-1:0] out_valid,
  output logic [LEN_W-1:0]     bits_left,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output state_t               state_dbg
);

  // Field bit counter must reach the wider of the two header fields minus one.
  localparam int FC_W = $clog2(((PORT_W > LEN_W) ? PORT_W : LEN_W) + 1);

  state_t            state, state_nxt;
  logic [FC_W-1:0]   field_cnt;
  logic [PORT_W-1:0] addr;
  logic [LEN_W-1:0]  len_sr, len_nxt;
  logic              field_last_addr, field_last_len, addr_ok;
  logic              cnt_load, cnt_en, cnt_zero;

  assign len_nxt         = LEN_W'({len_sr, ser_in});
  assign field_last_addr = (field_cnt == FC_W'(PORT_W - 1));
  assign field_last_len  = (field_cnt == FC_W'(LEN_W - 1));
  assign addr_ok         = (int'(addr) < NUM_PORTS);
  assign state_dbg       = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!ser_in) state_nxt = ADDR;
      ADDR: if (field_last_addr) state_nxt = LEN;
      LEN:  if (field_last_len) state_nxt = (len_nxt != '0) ? DATA : DONE;
      DATA: if (cnt_zero || (bits_left == LEN_W'(1))) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    err      = (state == DONE) && !addr_ok;
    cnt_load = (state == LEN) && field_last_len;
    cnt_en   = (state == DATA);
  end

  // out_valid qualifies ser_out for exactly one cycle per payload bit; there is
  // no ready, so a consumer must take every bit it sees qualified.
  always_ff @(posedge clk) begin
    if (rst) begin
      field_cnt <= '0;
      addr      <= '0;
      len_sr    <= '0;
      ser_out   <= '0;
      out_valid <= '0;
    end else begin
      if (state_nxt != state) field_cnt <= '0;
      else if ((state == ADDR) || (state == LEN)) field_cnt <= field_cnt + FC_W'(1);
      if (state == ADDR) addr <= PORT_W'({addr, ser_in});
      if (state == LEN) len_sr <= len_nxt;
      for (int p = 0; p < NUM_PORTS; p++) begin
        out_valid[p] <= (state == DATA) && (addr == PORT_W'(p));
        ser_out[p]   <= (state == DATA) && (addr == PORT_W'(p)) && ser_in;
      end
    end
  end

  param_down_counter #(.W(LEN_W)) u_len_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .en    (cnt_en),
    .din   (len_nxt),
    .count (bits_left),
    .zero  (cnt_zero)
  );

endmodule

// File: tb/tb_serial_frame_router.sv
// Directed bench for serial_frame_router: three configurations (defaults,
// NUM_PORTS=3, LEN_W=4) driven with hand-built frames and cycle-exact checks.
module tb_serial_frame_router;
  import serial_frame_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic si [3];

  logic [3:0] so_a, ov_a; logic [7:0] bl_a; logic bz_a, dn_a, er_a; state_t st_a;
  logic [2:0] so_b, ov_b; logic [7:0] bl_b; logic bz_b, dn_b, er_b; state_t st_b;
  logic [3:0] so_c, ov_c; logic [3:0] bl_c; logic bz_c, dn_c, er_c; state_t st_c;

  serial_frame_router dut_a (
    .clk(clk), .rst(rst), .ser_in(si[0]), .ser_out(so_a), .out_valid(ov_a),
    .bits_left(bl_a), .busy(bz_a), .done(dn_a), .err(er_a), .state_dbg(st_a));

  serial_frame_router #(.NUM_PORTS(3)) dut_b (
    .clk(clk), .rst(rst), .ser_in(si[1]), .ser_out(so_b), .out_valid(ov_b),
    .bits_left(bl_b), .busy(bz_b), .done(dn_b), .err(er_b), .state_dbg(st_b));

  serial_frame_router #(.LEN_W(4)) dut_c (
    .clk(clk), .rst(rst), .ser_in(si[2]), .ser_out(so_c), .out_valid(ov_c),
    .bits_left(bl_c), .busy(bz_c), .done(dn_c), .err(er_c), .state_dbg(st_c));

  logic [3:0] so_o [3];
  logic [3:0] ov_o [3];
  logic [7:0] bl_o [3];
  logic       bz_o [3];
  logic       dn_o [3];
  logic       er_o [3];
  logic [2:0] st_o [3];

  always_comb begin
    so_o[0] = so_a;          ov_o[0] = ov_a;          bl_o[0] = bl_a;
    so_o[1] = {1'b0, so_b};  ov_o[1] = {1'b0, ov_b};  bl_o[1] = bl_b;
    so_o[2] = so_c;          ov_o[2] = ov_c;          bl_o[2] = {4'd0, bl_c};
    bz_o[0] = bz_a; bz_o[1] = bz_b; bz_o[2] = bz_c;
    dn_o[0] = dn_a; dn_o[1] = dn_b; dn_o[2] = dn_c;
    er_o[0] = er_a; er_o[1] = er_b; er_o[2] = er_c;
    st_o[0] = st_a; st_o[1] = st_b; st_o[2] = st_c;
  end

  // scoreboard
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input int d, input string tag, input logic [3:0] so, input logic [3:0] ov,
                         input logic [7:0] bl, input logic bz, input logic dn, input logic er,
                         input logic [2:0] st);
    check({tag, " ser_out"},   32'(so_o[d]), 32'(so));
    check({tag, " out_valid"}, 32'(ov_o[d]), 32'(ov));
    check({tag, " bits_left"}, 32'(bl_o[d]), 32'(bl));
    check({tag, " busy"},      32'(bz_o[d]), 32'(bz));
    check({tag, " done"},      32'(dn_o[d]), 32'(dn));
    check({tag, " err"},       32'(er_o[d]), 32'(er));
    check({tag, " state"},     32'(st_o[d]), 32'(st));
  endtask

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic fbit(input int t, input int pw, input int lw, input int addr,
                                input int len, input logic [31:0] pl);
    if (t == 0) return 1'b0;
    if (t <= pw) return ((addr >> (pw - t)) & 1) != 0;
    if (t <= pw + lw) return ((len >> (pw + lw - t)) & 1) != 0;
    if (t <= pw + lw + len) return pl[t - pw - lw - 1];
    return 1'b1;
  endfunction

  // Cycle t is the cycle whose rising edge samples frame bit t; outputs seen
  // before that edge are the cycle-t outputs. Payload bit k is pl[k].
  task automatic run_frame(input int d, input int pw, input int lw, input int np,
                           input int addr, input int len, input logic [31:0] pl,
                           input logic done_bit, input int abort_at, input string tag);
    int ds, dc;
    logic [3:0] ov_e, so_e;
    logic [7:0] bl_e;
    logic [2:0] st_e;
    ds = pw + lw + 1;
    dc = ds + len;
    for (int t = 0; t <= dc; t++) begin
      si[d] = (t == dc) ? done_bit : fbit(t, pw, lw, addr, len, pl);
      ov_e = 4'd0;
      so_e = 4'd0;
      if ((addr < np) && (t > ds)) begin
        ov_e = 4'(1 << addr);
        so_e = pl[t - ds - 1] ? ov_e : 4'd0;
      end
      bl_e = ((t >= ds) && (t < dc)) ? 8'(len - (t - ds)) : 8'd0;
      if (t == dc)           st_e = DONE;
      else if (t == 0)       st_e = IDLE;
      else if (t <= pw)      st_e = ADDR;
      else if (t <= pw + lw) st_e = LEN;
      else                   st_e = DATA;
      chk_all(d, $sformatf("%s c%0d", tag, t), so_e, ov_e, bl_e, t >= 1, t == dc,
              (t == dc) && (addr >= np), st_e);
      if (t == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        si[d] = 1'b1;
        chk_all(d, {tag, " post-rst"}, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, IDLE);
        return;
      end
      step();
    end
    si[d] = 1'b1;
  endtask

  task automatic idle_cycles(input int d, input int n, input string tag);
    si[d] = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk_all(d, $sformatf("%s i%0d", tag, i), 4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, IDLE);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++) si[d] = 1'b1;
    rst = 1'b1;
    step();
    step();
    for (int d = 0; d < 3; d++)
      chk_all(d, $sformatf("reset d%0d", d), 4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, IDLE);
    rst = 1'b0;
    step();

    // addr=2, len=3, payload 1,0,1; then back-to-back len=0 frame with a 0 in DONE
    run_frame(0, 2, 8, 4, 2, 3, 32'b101, 1'b1, -1, "f_a2_l3");
    run_frame(0, 2, 8, 4, 1, 0, 32'd0, 1'b0, -1, "f_a1_l0");
    idle_cycles(0, 3, "after_done0");

    // back-to-back pair
    run_frame(0, 2, 8, 4, 0, 4, 32'b0110, 1'b1, -1, "f_a0_l4");
    run_frame(0, 2, 8, 4, 3, 2, 32'b10, 1'b1, -1, "f_a3_l2");

    // reset in DATA after the first of five payload bits, then a clean frame
    run_frame(0, 2, 8, 4, 1, 5, 32'b10110, 1'b1, 12, "f_abort");
    idle_cycles(0, 1, "after_abort");
    run_frame(0, 2, 8, 4, 2, 2, 32'b11, 1'b1, -1, "f_after_rst");

    // NUM_PORTS=3: out-of-range address, then a legal one
    run_frame(1, 2, 8, 3, 3, 2, 32'b11, 1'b1, -1, "b_a3_err");
    run_frame(1, 2, 8, 3, 2, 1, 32'b1, 1'b1, -1, "b_a2_l1");

    // LEN_W=4: maximum payload to port 0
    run_frame(2, 2, 4, 4, 0, 15, 32'h5A3C, 1'b1, -1, "c_a0_l15");
    idle_cycles(2, 2, "c_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_router.md
# serial_frame_router

Parametrised successor of the 8-bit serial bit transmitter. It receives a framed serial stream on one input: start bit, destination port address, then data-length field. The block then forwards exactly that many data bits to the selected one of NUM_PORTS serial outputs, using an internal loadable down-counter in place of the fixed 8-bit count-enable scheme. It sits between the serial line front end and the per-channel consumers.

## Interface
- NUM_PORTS, 4, number of serial output channels (>=1)
- PORT_W, $clog2(NUM_PORTS) (min 1), address field width in bits
- LEN_W, 8, length field width; max payload 2^LEN_W-1 bits
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- ser_in  input  1  serial line; idles high, sampled every rising edge
- ser_out  output  NUM_PORTS  per-port serial data, registered
- out_valid  output  NUM_PORTS  per-port qualifier; one-hot or zero
- bits_left  output  LEN_W  remaining payload bits (counter value)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at end of a frame
- err  output  1  one-cycle pulse with done when address >= NUM_PORTS

## Operation
- Frame: start bit (0), PORT_W address bits MSB first, LEN_W length bits MSB first, then N payload bits.
- States and transitions:
  - IDLE: stays while ser_in=1; ser_in=0 -> ADDR.
  - ADDR: shift PORT_W bits into the address register; after the last bit -> LEN.
  - LEN: shift LEN_W bits into the length shift register; after the last bit, load the counter -> DATA if N>0, else -> DONE.
  - DATA: each cycle, register ser_in to ser_out[addr] and set out_valid[addr]=1; decrement the counter; when the counter reaches 1 on a sample -> DONE.
  - DONE: one cycle; ser_in ignored -> IDLE.
- Address >= NUM_PORTS: payload is consumed and counted, ser_out/out_valid stay 0, err=1 with done.
- bits_left holds the loaded length on entry to DATA, decrements per sampled bit, and reads 0 in DONE/IDLE.
- Non-selected ser_out bits hold 0.
- Reset values: state IDLE; ser_out=0, out_valid=0, bits_left=0, busy=0, done=0, err=0; address/length registers cleared.
- rst mid-frame aborts with no done or err pulse. rst wins over every other event in the same cycle.

## Timing
- With the start bit sampled at cycle 0:
  - ADDR occupies cycles 1..PORT_W.
  - LEN occupies cycles PORT_W+1..PORT_W+LEN_W.
  - DATA occupies the next N cycles.
  - DONE occurs at cycle PORT_W+LEN_W+N+1.
- Payload latency is 1 cycle: the bit sampled at cycle t appears on ser_out at t+1 with out_valid. The last payload bit's out_valid coincides with done.
- The earliest next start bit is sampled at DONE+1. A 0 on ser_in during DONE is not a start bit.
- N=0: DONE directly follows the last length bit; out_valid never asserts.
- busy rises in the cycle after the start bit is sampled and falls in the cycle after DONE.

## Structure
- Package serial_frame_pkg: state enum (IDLE, ADDR, LEN, DATA, DONE) and default parameter constants.
- Sub-module param_down_counter: width LEN_W, with synchronous rst, load, en, parallel in, count out, and zero flag. It replaces the old fixed 8-bit counter.
- Top level: FSM, field-width bit counter, address/length shift registers, output demux registers.

## Test plan
- Defaults, frame addr=2, len=3, payload 1,0,1 -> ser_out[2]=1,0,1 on cycles 12..14; out_valid=4'b0100 on those cycles; done at cycle 14; err=0.
- len=0, addr=1 -> done at cycle 11; out_valid stays 0; busy high on cycles 1..11.
- Back-to-back frames with the second start bit at DONE+1 -> both frames forwarded correctly. A 0 on ser_in exactly in DONE is ignored.
- NUM_PORTS=3, addr=3, len=2 -> no out_valid, bits_left counts 2,1, done and err pulse together.
- rst asserted in DATA after 1 of 5 bits -> next cycle all outputs 0, state IDLE, no done. The following frame is routed normally.
- LEN_W=4, len=15 to port 0 -> 15 valid bits, bits_left counts 15..1, done at cycle 2+4+15+1=22 (PORT_W=2).
